prim_ram_1p_arb: RTL and testbench

- Shares one single-port RAM (prim_generic_ram_1p semantics) between two requesters, A (host bus) and B (DMA/scrubber).
- Round-robin arbitration with a same-cycle grant.
- Routes each read response back to the requester that issued it.
- Owns the RAM zeroization sweep, run after reset and on request; all grants are blocked while the sweep runs.

---
 rtl/prim_ram_arb_pkg.sv | 18 +
 rtl/prim_ram_init_seq.sv | 47 ++++
 rtl/prim_ram_1p_arb.sv | 153 +++++++++++++++
 tb/tb_prim_ram_1p_arb.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/prim_ram_arb_pkg.sv
// Shared types for the single-port RAM arbiter: FSM states and read-response owner.
// Latency: n/a (types only).
// Backpressure: n/a.
package prim_ram_arb_pkg;

  typedef enum logic [1:0] {
    RESET_ST = 2'd0,
    INIT_ST  = 2'd1,
    READY_ST = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_A    = 2'd1,
    OWN_B    = 2'd2
  } owner_e;

endpackage

// File: rtl/prim_ram_init_seq.sv
// Zeroization sweep address counter: start pulse, busy while sweeping, done on last word.
// Latency: addr_o = 0 the cycle after start_i; one address per cycle; exactly Depth busy cycles.
// Backpressure: none; start_i while busy is ignored, so a sweep cannot be restarted or extended.
// Ports: clk_i/rst_ni clock and async active-low reset; start_i begin sweep;
//        busy_o sweep in progress; addr_o current word; done_o high on the final word.
module prim_ram_init_seq #(
  parameter int Depth = 128,
  parameter int Aw    = $clog2(Depth)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          busy_o,
  output logic [Aw-1:0] addr_o,
  output logic          done_o
);

  localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);

  logic [Aw-1:0] cnt_q;
  logic          busy_q;
  logic          last;

  // Compare against Depth-1 rather than relying on overflow: Depth need not be a power of two.
  assign last = (cnt_q == LastAddr);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (busy_q) begin
      if (last) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (start_i) begin
      busy_q <= 1'b1;
    end
  end

  assign busy_o = busy_q;
  assign addr_o = cnt_q;
  assign done_o = busy_q & last;

endmodule

// File: rtl/prim_ram_1p_arb.sv
// Two-requester round-robin arbiter for one single-port RAM, with read-response routing and zeroization sweep.
// Latency: grant and RAM access in the same cycle; read data returns with ram_rvalid_i one cycle later.
// Backpressure: requester holds req/payload until its gnt; all grants held low while sweeping.
// Ports: a_*/b_* requester buses (req/gnt/write/addr/wdata/wmask in, rvalid/rdata out);
//        ram_* RAM-side bus; init_req_i sweep request pulse; init_done_o memory ready.
module prim_ram_1p_arb
  import prim_ram_arb_pkg::*;
#(
  parameter int Width       = 32,
  parameter int Depth       = 128,
  parameter bit InitOnReset = 1'b1,
  localparam int Aw         = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             a_req_i,
  output logic             a_gnt_o,
  input  logic             a_write_i,
  input  logic [Aw-1:0]    a_addr_i,
  input  logic [Width-1:0] a_wdata_i,
  input  logic [Width-1:0] a_wmask_i,
  output logic             a_rvalid_o,
  output logic [Width-1:0] a_rdata_o,
  input  logic             b_req_i,
  output logic             b_gnt_o,
  input  logic             b_write_i,
  input  logic [Aw-1:0]    b_addr_i,
  input  logic [Width-1:0] b_wdata_i,
  input  logic [Width-1:0] b_wmask_i,
  output logic             b_rvalid_o,
  output logic [Width-1:0] b_rdata_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic             ram_rvalid_i,
  input  logic [Width-1:0] ram_rdata_i,
  input  logic             init_req_i,
  output logic             init_done_o
);

  state_e        state_q, state_d;
  owner_e        owner_q;
  logic          prio_b_q;   // 0: A wins a tie, 1: B wins a tie
  logic          init_done_q;
  logic          seq_start, seq_busy, seq_done;
  logic [Aw-1:0] seq_addr;
  logic          ready;

  prim_ram_init_seq #(
    .Depth (Depth),
    .Aw    (Aw)
  ) u_init_seq (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (seq_start),
    .busy_o  (seq_busy),
    .addr_o  (seq_addr),
    .done_o  (seq_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RESET_ST;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    seq_start = 1'b0;
    unique case (state_q)
      RESET_ST: begin
        if (InitOnReset) begin
          state_d   = INIT_ST;
          seq_start = 1'b1;
        end else begin
          state_d = READY_ST;
        end
      end
      INIT_ST: begin
        if (seq_done) state_d = READY_ST;
      end
      READY_ST: begin
        if (init_req_i) begin
          state_d   = INIT_ST;
          seq_start = 1'b1;
        end
      end
      default: state_d = RESET_ST;
    endcase
  end

  assign ready   = (state_q == READY_ST);
  assign a_gnt_o = ready & a_req_i & (~b_req_i | ~prio_b_q);
  assign b_gnt_o = ready & b_req_i & (~a_req_i |  prio_b_q);

  // The sweep owns the RAM port outright; otherwise the granted requester is muxed through.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_write_o = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_wmask_o = '0;
    if (state_q == INIT_ST) begin
      ram_req_o   = 1'b1;
      ram_write_o = 1'b1;
      ram_addr_o  = seq_addr;
      ram_wmask_o = '1;
    end else if (a_gnt_o) begin
      ram_req_o   = 1'b1;
      ram_write_o = a_write_i;
      ram_addr_o  = a_addr_i;
      ram_wdata_o = a_wdata_i;
      ram_wmask_o = a_wmask_i;
    end else if (b_gnt_o) begin
      ram_req_o   = 1'b1;
      ram_write_o = b_write_i;
      ram_addr_o  = b_addr_i;
      ram_wdata_o = b_wdata_i;
      ram_wmask_o = b_wmask_i;
    end
  end

  // owner tracks the one read in flight; it is updated even on the cycle the sweep starts,
  // so a read granted alongside init_req_i still gets its response routed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_b_q    <= 1'b0;
      owner_q     <= OWN_NONE;
      init_done_q <= 1'b0;
    end else begin
      if (a_gnt_o)      prio_b_q <= 1'b1;
      else if (b_gnt_o) prio_b_q <= 1'b0;

      if (a_gnt_o && !a_write_i)      owner_q <= OWN_A;
      else if (b_gnt_o && !b_write_i) owner_q <= OWN_B;
      else                            owner_q <= OWN_NONE;

      init_done_q <= (state_d == READY_ST);
    end
  end

  assign init_done_o = init_done_q;
  assign a_rvalid_o  = ram_rvalid_i & (owner_q == OWN_A);
  assign b_rvalid_o  = ram_rvalid_i & (owner_q == OWN_B);
  assign a_rdata_o   = ram_rdata_i;
  assign b_rdata_o   = ram_rdata_i;

  // seq_busy mirrors INIT_ST; kept for readability of the sequencer interface.
  logic unused_busy;
  assign unused_busy = seq_busy;

endmodule

// File: tb/tb_prim_ram_1p_arb.sv
// Directed bench for prim_ram_1p_arb: u0 (Depth 128, sweep on reset) with a RAM model,
// u1 (Depth 100, no sweep on reset) for the non-power-of-two depth case.
// Inputs driven 1 time unit after posedge; outputs checked before the next edge.
module tb_prim_ram_1p_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n      = 0;

  // u0 stimulus and observation
  logic        rst_n, init_req;
  logic        a_req, a_write, b_req, b_write;
  logic [6:0]  a_addr, b_addr;
  logic [31:0] a_wdata, a_wmask, b_wdata, b_wmask;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid, init_done;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_req, ram_write, ram_rvalid;
  logic [6:0]  ram_addr;
  logic [31:0] ram_wdata, ram_wmask, ram_rdata;

  // u1 stimulus and observation
  logic        rst1_n, init1_req;
  logic        u1_a_gnt, u1_b_gnt, u1_a_rvalid, u1_b_rvalid, u1_done;
  logic [31:0] u1_a_rdata, u1_b_rdata, u1_wdata, u1_wmask;
  logic        u1_req, u1_write;
  logic [6:0]  u1_addr;

  prim_ram_1p_arb #(.Width(32), .Depth(128), .InitOnReset(1'b1)) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_gnt_o(a_gnt), .a_write_i(a_write), .a_addr_i(a_addr),
    .a_wdata_i(a_wdata), .a_wmask_i(a_wmask), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_gnt_o(b_gnt), .b_write_i(b_write), .b_addr_i(b_addr),
    .b_wdata_i(b_wdata), .b_wmask_i(b_wmask), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_wmask_o(ram_wmask),
    .ram_rvalid_i(ram_rvalid), .ram_rdata_i(ram_rdata),
    .init_req_i(init_req), .init_done_o(init_done)
  );

  prim_ram_1p_arb #(.Width(32), .Depth(100), .InitOnReset(1'b0)) u1 (
    .clk_i(clk), .rst_ni(rst1_n),
    .a_req_i(1'b0), .a_gnt_o(u1_a_gnt), .a_write_i(1'b0), .a_addr_i(7'd0),
    .a_wdata_i(32'd0), .a_wmask_i(32'd0), .a_rvalid_o(u1_a_rvalid), .a_rdata_o(u1_a_rdata),
    .b_req_i(1'b0), .b_gnt_o(u1_b_gnt), .b_write_i(1'b0), .b_addr_i(7'd0),
    .b_wdata_i(32'd0), .b_wmask_i(32'd0), .b_rvalid_o(u1_b_rvalid), .b_rdata_o(u1_b_rdata),
    .ram_req_o(u1_req), .ram_write_o(u1_write), .ram_addr_o(u1_addr),
    .ram_wdata_o(u1_wdata), .ram_wmask_o(u1_wmask),
    .ram_rvalid_i(1'b0), .ram_rdata_i(32'd0),
    .init_req_i(init1_req), .init_done_o(u1_done)
  );

  // Single-port RAM model for u0: bit-masked write, read data one cycle after request.
  logic [31:0] mem [128];
  always @(posedge clk) begin
    ram_rvalid <= ram_req & ~ram_write;
    if (ram_req && !ram_write) ram_rdata <= mem[ram_addr];
    if (ram_req && ram_write)  mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
  end

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish, expected finish within 500000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic r, input logic w, input logic [6:0] ad,
                       input logic [31:0] d, input logic [31:0] m);
    a_req = r; a_write = w; a_addr = ad; a_wdata = d; a_wmask = m;
  endtask

  task automatic set_b(input logic r, input logic w, input logic [6:0] ad,
                       input logic [31:0] d, input logic [31:0] m);
    b_req = r; b_write = w; b_addr = ad; b_wdata = d; b_wmask = m;
  endtask

  // Called on the first INIT cycle of u0; counts sweep writes until init_done rises.
  task automatic run_sweep(input int pulse_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (init_done) break;
      chk("sweep_addr", 32'(ram_addr), cnt);
      chk("sweep_ctl", 32'({ram_req, ram_write, a_gnt, b_gnt}), 32'h0000000C);
      chk("sweep_data", ram_wdata, 32'h0);
      chk("sweep_mask", ram_wmask, 32'hFFFFFFFF);
      cnt++;
      init_req = (i == pulse_at);
      tick();
    end
    init_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0; init_req = 1'b0; init1_req = 1'b0;
    set_a(1'b1, 1'b0, 7'd0, 32'd0, 32'd0);
    set_b(1'b1, 1'b0, 7'd0, 32'd0, 32'd0);
    tick(); tick();
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_gnt", 32'({a_gnt, b_gnt}), 32'd0);
    chk("rst_ram_req", 32'(ram_req), 32'd0);
    chk("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    chk("u1_rst_done", 32'(u1_done), 32'd0);

    // Release: u0 sweeps with both requesters pending, u1 goes straight to ready.
    rst_n = 1'b1; rst1_n = 1'b1;
    tick();
    chk("u1_done_1cyc", 32'(u1_done), 32'd1);
    chk("u1_no_write", 32'(u1_req), 32'd0);
    run_sweep(-1, n);
    chk("sweep1_len", n, 32'd128);
    chk("sweep1_done", 32'(init_done), 32'd1);
    set_a(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    set_b(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    #1;
    chk("idle_ram_req", 32'(ram_req), 32'd0);

    // Simultaneous writes: prio starts at A, then B is served next cycle.
    set_a(1'b1, 1'b1, 7'h10, 32'h11111111, 32'hFFFFFFFF);
    set_b(1'b1, 1'b1, 7'h20, 32'h22222222, 32'hFFFFFFFF);
    #1;
    chk("wr_tie_gnt", 32'({a_gnt, b_gnt}), 32'h2);
    chk("wr_tie_addr", 32'(ram_addr), 32'h10);
    tick();
    set_a(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    #1;
    chk("wr_b_gnt", 32'({a_gnt, b_gnt}), 32'h1);
    chk("wr_b_addr", 32'(ram_addr), 32'h20);
    tick();

    // Both read every cycle: grants alternate A,B,A,B; responses follow one cycle later.
    set_a(1'b1, 1'b0, 7'h10, 32'd0, 32'd0);
    set_b(1'b1, 1'b0, 7'h20, 32'd0, 32'd0);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("rr_a_gnt", 32'(a_gnt), 32'(k % 2 == 0));
      chk("rr_b_gnt", 32'(b_gnt), 32'(k % 2 == 1));
      chk("rr_addr", 32'(ram_addr), (k % 2 == 0) ? 32'h10 : 32'h20);
      chk("rr_a_rvalid", 32'(a_rvalid), 32'(k % 2 == 1));
      chk("rr_b_rvalid", 32'(b_rvalid), 32'(k > 0 && k % 2 == 0));
      if (k > 0) chk("rr_rdata", a_rdata, (k % 2 == 1) ? 32'h11111111 : 32'h22222222);
      tick();
    end
    set_a(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    set_b(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    #1;
    chk("rr_last_rvalid", 32'({a_rvalid, b_rvalid}), 32'h1);
    chk("rr_last_rdata", b_rdata, 32'h22222222);

    // Masked write by B, read back by A.
    set_b(1'b1, 1'b1, 7'd5, 32'hDEADBEEF, 32'hFFFF0000);
    #1;
    chk("mask_wr_gnt", 32'({a_gnt, b_gnt}), 32'h1);
    tick();
    set_b(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    set_a(1'b1, 1'b0, 7'd5, 32'd0, 32'd0);
    #1;
    chk("mask_rd_gnt", 32'({a_gnt, b_gnt}), 32'h2);
    tick();
    set_a(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    chk("mask_rd_rvalid", 32'({a_rvalid, b_rvalid}), 32'h2);
    chk("mask_rd_data", a_rdata, 32'hDEAD0000);

    // Read granted together with init_req; response lands in first INIT cycle.
    set_a(1'b1, 1'b0, 7'h10, 32'd0, 32'd0);
    init_req = 1'b1;
    #1;
    chk("init_rd_gnt", 32'(a_gnt), 32'd1);
    tick();
    init_req = 1'b0;
    set_a(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    chk("init_rd_rvalid", 32'({a_rvalid, b_rvalid}), 32'h2);
    chk("init_rd_data", a_rdata, 32'h11111111);
    chk("init_done_low", 32'(init_done), 32'd0);
    run_sweep(3, n);
    chk("sweep2_len", n, 32'd128);

    // Memory is zeroed again.
    set_a(1'b1, 1'b0, 7'd5, 32'd0, 32'd0);
    #1;
    chk("post_sweep_gnt", 32'(a_gnt), 32'd1);
    tick();
    set_a(1'b0, 1'b0, 7'd0, 32'd0, 32'd0);
    chk("post_sweep_rvalid", 32'(a_rvalid), 32'd1);
    chk("post_sweep_data", a_rdata, 32'h0);

    // Reset at sweep address 40 aborts; a fresh sweep restarts from 0.
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("mid_addr", 32'(ram_addr), 32'd40);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ram_req", 32'(ram_req), 32'd0);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_sweep(-1, n);
    chk("sweep3_len", n, 32'd128);

    // u1: Depth 100 sweep on request, then counter back at 0.
    init1_req = 1'b1;
    tick();
    init1_req = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (u1_done) break;
      chk("u1_sweep_addr", 32'(u1_addr), n);
      chk("u1_sweep_ctl", 32'({u1_req, u1_write}), 32'h3);
      n++;
      tick();
    end
    chk("u1_sweep_len", n, 32'd100);
    chk("u1_done_again", 32'(u1_done), 32'd1);
    init1_req = 1'b1;
    tick();
    init1_req = 1'b0;
    chk("u1_restart_addr", 32'(u1_addr), 32'd0);
    chk("u1_restart_req", 32'(u1_req), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
